sort_ctrl_8_bit: RTL and testbench
==================================

Name: sort_ctrl_8_bit

Overview:
- Sequencer that buffers DEPTH unsigned 8-bit words and sorts them in place with a bubble sort.
- Uses exactly one shared 8-bit magnitude comparator, doing one compare per clock cycle.
- Streams the sorted words out over a valid/ready handshake.
- Sits between a producer stream and a consumer that needs ordered data, e.g. a median or threshold picker.

Parameters:
- DEPTH, 8, number of words per batch; legal range 2..16.

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  synchronous active-high reset
- desc_i  input  1  sort direction: 0 ascending, 1 descending; sampled on the first accepted input word
- abort_i  input  1  synchronous abort; returns the block to IDLE
- in_valid_i  input  1  input word valid
- in_ready_o  output  1  block can accept an input word
- in_data_i  input  8  input word, unsigned
- out_valid_o  output  1  sorted word valid
- out_ready_i  input  1  consumer accepts the output word
- out_data_o  output  8  sorted word; 0 when out_valid_o=0
- out_last_o  output  1  marks the final word of the batch
- busy_o  output  1  high in LOAD, SORT or DRAIN
- done_o  output  1  one-cycle pulse after the last output handshake
- cmp_count_o  output  8  compares performed in the current or most recent batch

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high, on clk_i/rst_i.
- Reset values: state=IDLE, all counters 0, direction=0, in_ready_o=0, out_valid_o=0, out_data_o=0, out_last_o=0, busy_o=0, done_o=0, cmp_count_o=0. Buffer contents don't care.
- Input handshake: a word is accepted when in_valid_i & in_ready_o.
- Output handshake: a word is transferred when out_valid_o & out_ready_i.
- States: IDLE, LOAD, SORT, DRAIN.
- IDLE:
  - in_ready_o=1.
  - First accepted word goes to buf[0]. desc_i is latched, cmp_count_o clears to 0, state goes to LOAD with wr_idx=1.
- LOAD:
  - in_ready_o=1; each accepted word goes to buf[wr_idx] and wr_idx increments.
  - Acceptance of word DEPTH-1 (index) moves to SORT on the next edge. No bubbles are required; DEPTH back-to-back words take DEPTH cycles.
- SORT:
  - in_ready_o=0. Every cycle compares buf[j] with buf[j+1] (j starts at 0, pass p starts at 0) and increments cmp_count_o.
  - Ascending swaps when buf[j] > buf[j+1]. Descending swaps when buf[j] < buf[j+1]. Equal values never swap, so the sort is stable.
  - Swap and index update happen on the same edge. Exactly one compare per cycle; no idle cycles inside SORT.
  - End of pass is reached when j = DEPTH-2-p. If no swap occurred in that pass, or p = DEPTH-2, go to DRAIN. Otherwise p increments, j resets to 0 and the swap flag clears.
  - SORT duration in cycles equals the final cmp_count_o. Minimum is DEPTH-1 (presorted input). Maximum is DEPTH*(DEPTH-1)/2.
- DRAIN:
  - out_valid_o=1, out_data_o=buf[rd_idx], out_last_o=(rd_idx=DEPTH-1). rd_idx starts at 0 and advances on each handshake.
  - out_data_o must hold stable while out_ready_i=0.
  - Handshake on the last word moves to IDLE; done_o=1 in the first IDLE cycle only.
- busy_o=1 exactly in LOAD, SORT and DRAIN.
- cmp_count_o holds its value in IDLE until the next batch starts.
- abort_i:
  - In any state, forces IDLE on the next edge and clears all counters except cmp_count_o. No done_o pulse.
  - abort_i has priority over a handshake in the same cycle; the word is treated as not accepted or not transferred.
- rst_i has priority over abort_i and everything else. Reset mid-operation discards the batch.
- A new batch may begin in the same cycle done_o is high (IDLE accepts input).

Test Plan:
- Ascending, DEPTH=8, input 0x10,0x20,...,0x80 (presorted): SORT lasts 7 cycles, cmp_count_o=7, output identical order, out_last_o on 0x80, one done_o pulse.
- Ascending, input 0xFF,0xE0,0xC0,0xA0,0x80,0x40,0x20,0x00: cmp_count_o=28, SORT lasts 28 cycles, output 0x00..0xFF reversed order.
- Descending, input 0x05,0x80,0x05,0xFF,0x00,0x7F,0x80,0x01: output 0xFF,0x80,0x80,0x7F,0x05,0x05,0x01,0x00.
- Output backpressure: hold out_ready_i=0 for 5 cycles, then toggle it every cycle. Every word appears exactly once, in order; out_data_o is stable while stalled; done_o fires once, after the last handshake.
- Reset or abort mid-SORT (cycle 3 of SORT): next cycle is IDLE with busy_o=0, out_valid_o=0, in_ready_o=1. A new presorted batch then sorts correctly with cmp_count_o=7.
- Input gaps: in_valid_i deasserted for 2 cycles between words 3 and 4. Load completes with 8 words total and in_ready_o drops only on entry to SORT.

Source files
------------

// File: rtl/sort_ctrl_8_bit.sv
// sort_ctrl_8_bit: buffers DEPTH unsigned bytes, bubble-sorts them in place
// with a single shared comparator (one compare per cycle), then streams the
// sorted words out over a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   desc_i            sort direction (0 ascending, 1 descending), latched on first word
//   abort_i           synchronous return to IDLE, batch discarded
//   in_valid_i/in_ready_o/in_data_i       input stream
//   out_valid_o/out_ready_i/out_data_o/out_last_o  sorted output stream
//   busy_o            high in LOAD, SORT, DRAIN
//   done_o            one-cycle pulse after the last output handshake
//   cmp_count_o       compares performed in the current or most recent batch
module sort_ctrl_8_bit #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       desc_i,
    input  logic       abort_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_data_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_data_o,
    output logic       out_last_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] cmp_count_o
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(DEPTH - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SORT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]    j_q, j_d;
    logic [IDX_W-1:0]    p_q, p_d;
    logic                swapped_q, swapped_d;
    logic                desc_q, desc_d;
    logic [CNT_W-1:0]    cmp_q, cmp_d;

    logic                in_ready_d, out_valid_d, out_last_d, busy_d, done_d;
    logic [DATA_W-1:0]   out_data_d;

    logic                in_fire, out_fire;
    logic [IDX_W-1:0]    j_nxt;
    logic [DATA_W-1:0]   cmp_a, cmp_b, cmp_lhs, cmp_rhs;
    logic                swap_c;
    logic                pass_end;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    // Single magnitude comparator; direction is applied by swapping its operands.
    assign j_nxt    = j_q + IDX_W'(1);
    assign cmp_a    = mem_q[j_q];
    assign cmp_b    = mem_q[j_nxt];
    assign cmp_lhs  = desc_q ? cmp_b : cmp_a;
    assign cmp_rhs  = desc_q ? cmp_a : cmp_b;
    assign swap_c   = (cmp_lhs > cmp_rhs);
    assign pass_end = (j_q == (LAST_PASS - p_q));

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        j_d       = j_q;
        p_d       = p_q;
        swapped_d = swapped_q;
        desc_d    = desc_q;
        cmp_d     = cmp_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    mem_d[0] = in_data_i;
                    desc_d   = desc_i;
                    cmp_d    = '0;
                    wr_idx_d = IDX_W'(1);
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (in_fire) begin
                    mem_d[wr_idx_q] = in_data_i;
                    if (wr_idx_q == LAST_IDX) begin
                        state_d   = SORT;
                        wr_idx_d  = '0;
                        j_d       = '0;
                        p_d       = '0;
                        swapped_d = 1'b0;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                end
            end
            SORT: begin
                cmp_d = cmp_q + CNT_W'(1);
                if (swap_c) begin
                    mem_d[j_q]   = cmp_b;
                    mem_d[j_nxt] = cmp_a;
                end
                if (pass_end) begin
                    // A pass with no swap means the buffer is already ordered.
                    if (!(swapped_q || swap_c) || (p_q == LAST_PASS)) begin
                        state_d  = DRAIN;
                        rd_idx_d = '0;
                    end else begin
                        p_d       = p_q + IDX_W'(1);
                        j_d       = '0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    j_d       = j_nxt;
                    swapped_d = swapped_q | swap_c;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if (rd_idx_q == LAST_IDX) begin
                        state_d  = IDLE;
                        rd_idx_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over any handshake in the same cycle; compare count is kept.
        if (abort_i) begin
            state_d   = IDLE;
            wr_idx_d  = '0;
            rd_idx_d  = '0;
            j_d       = '0;
            p_d       = '0;
            swapped_d = 1'b0;
            done_d    = 1'b0;
        end

        in_ready_d  = (state_d == IDLE) || (state_d == LOAD);
        out_valid_d = (state_d == DRAIN);
        out_data_d  = (state_d == DRAIN) ? mem_d[rd_idx_d] : '0;
        out_last_d  = (state_d == DRAIN) && (rd_idx_d == LAST_IDX);
        busy_d      = (state_d != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            j_q         <= '0;
            p_q         <= '0;
            swapped_q   <= 1'b0;
            desc_q      <= 1'b0;
            cmp_q       <= '0;
            in_ready_o  <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            j_q         <= j_d;
            p_q         <= p_d;
            swapped_q   <= swapped_d;
            desc_q      <= desc_d;
            cmp_q       <= cmp_d;
            in_ready_o  <= in_ready_d;
            out_valid_o <= out_valid_d;
            out_data_o  <= out_data_d;
            out_last_o  <= out_last_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
        end
    end

    // Word buffer; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign cmp_count_o = cmp_q;

endmodule

// File: tb/tb_sort_ctrl_8_bit.sv
// Self-checking bench for sort_ctrl_8_bit (DEPTH=8): directed batches with a
// scoreboard queue of expected sorted words, backpressure, abort and reset.
module tb_sort_ctrl_8_bit;

    localparam int unsigned DEPTH = 8;
    typedef logic [7:0] batch_t [DEPTH];

    logic       clk = 1'b0;
    logic       rst_i, desc_i, abort_i, in_valid_i, out_ready_i;
    logic [7:0] in_data_i;
    logic       in_ready_o, out_valid_o, out_last_o, busy_o, done_o;
    logic [7:0] out_data_o, cmp_count_o;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    sort_ctrl_8_bit #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .desc_i      (desc_i),
        .abort_i     (abort_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cmp_count_o (cmp_count_o)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input batch_t e);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(e[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed one batch; gap_after >= 0 drops in_valid_i for 2 cycles after that word.
    task automatic load_batch(input batch_t d, input logic desc, input int gap_after);
        int bound;
        desc_i = desc;
        for (int i = 0; i < DEPTH; i++) begin
            if (gap_after >= 0 && i == gap_after + 1) begin
                in_valid_i = 1'b0;
                for (int g = 0; g < 2; g++) begin
                    tick();
                    chk1("in_ready_gap", in_ready_o, 1'b1);
                    chk1("busy_gap", busy_o, 1'b1);
                end
            end
            in_valid_i = 1'b1;
            in_data_i  = d[i];
            bound = 0;
            while (in_ready_o !== 1'b1 && bound < 20) begin
                tick();
                bound++;
            end
            if (bound >= 20) chk1("in_ready_timeout", 1'b0, 1'b1);
            tick();
            if (i == 0) chk1("done_clear", done_o, 1'b0);
            chk1((i == DEPTH - 1) ? "in_ready_sort" : "in_ready_load", in_ready_o,
                 (i == DEPTH - 1) ? 1'b0 : 1'b1);
            chk1("busy_load", busy_o, 1'b1);
        end
        in_valid_i = 1'b0;
    endtask

    // Count SORT cycles (busy, not accepting, not presenting output).
    task automatic sort_phase(input int exp_cmps);
        int cyc = 0;
        while (busy_o === 1'b1 && out_valid_o === 1'b0 && in_ready_o === 1'b0 && cyc < 200) begin
            chk8("out_data_idle", out_data_o, 8'h00);
            tick();
            cyc++;
        end
        chk1("drain_entry", out_valid_o, 1'b1);
        if (exp_cmps >= 0) begin
            chki("sort_cycles", cyc, exp_cmps);
            chk8("cmp_count", cmp_count_o, 8'(exp_cmps));
        end
    endtask

    // Pop the scoreboard on each handshake; stall=1 holds ready low 5 cycles then toggles.
    task automatic drain_phase(input logic stall);
        int   k = 0;
        logic fire;
        while (exp_q.size() > 0 && k < 200) begin
            out_ready_i = stall ? ((k >= 5) && (((k - 5) % 2) == 0)) : 1'b1;
            chk1("out_valid", out_valid_o, 1'b1);
            chk8("out_data", out_data_o, exp_q[0]);
            chk1("out_last", out_last_o, exp_q.size() == 1);
            fire = out_ready_i;
            tick();
            k++;
            if (fire) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    chk1("done_pulse", done_o, 1'b1);
                    chk1("busy_after", busy_o, 1'b0);
                    chk1("out_valid_after", out_valid_o, 1'b0);
                    chk8("out_data_after", out_data_o, 8'h00);
                    chk1("in_ready_after", in_ready_o, 1'b1);
                end else begin
                    chk1("done_early", done_o, 1'b0);
                end
            end else begin
                chk1("done_stall", done_o, 1'b0);
            end
        end
        if (k >= 200) chk1("drain_timeout", 1'b0, 1'b1);
        out_ready_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        batch_t b;
        batch_t e;

        rst_i = 1'b1; desc_i = 1'b0; abort_i = 1'b0;
        in_valid_i = 1'b0; in_data_i = 8'h00; out_ready_i = 1'b0;
        repeat (2) tick();
        chk1("rst_in_ready", in_ready_o, 1'b0);
        chk1("rst_out_valid", out_valid_o, 1'b0);
        chk8("rst_out_data", out_data_o, 8'h00);
        chk1("rst_out_last", out_last_o, 1'b0);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_done", done_o, 1'b0);
        chk8("rst_cmp", cmp_count_o, 8'h00);
        rst_i = 1'b0;
        tick();
        chk1("idle_in_ready", in_ready_o, 1'b1);

        // Presorted ascending.
        b = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        push_exp(b);
        load_batch(b, 1'b0, -1);
        sort_phase(7);
        drain_phase(1'b0);

        // Reversed, ascending sort: worst case.
        b = '{8'hFF, 8'hE0, 8'hC0, 8'hA0, 8'h80, 8'h40, 8'h20, 8'h00};
        e = '{8'h00, 8'h20, 8'h40, 8'h80, 8'hA0, 8'hC0, 8'hE0, 8'hFF};
        push_exp(e);
        load_batch(b, 1'b0, -1);
        sort_phase(28);
        drain_phase(1'b0);

        // Descending with duplicates.
        b = '{8'h05, 8'h80, 8'h05, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h01};
        e = '{8'hFF, 8'h80, 8'h80, 8'h7F, 8'h05, 8'h05, 8'h01, 8'h00};
        push_exp(e);
        load_batch(b, 1'b1, -1);
        sort_phase(25);
        drain_phase(1'b0);

        // Output backpressure.
        b = '{8'h33, 8'h11, 8'h22, 8'h00, 8'h77, 8'h66, 8'h55, 8'h44};
        e = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        push_exp(e);
        load_batch(b, 1'b0, -1);
        sort_phase(-1);
        drain_phase(1'b1);

        // Abort in cycle 3 of SORT.
        b = '{8'h90, 8'h80, 8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20};
        load_batch(b, 1'b0, -1);
        chk1("sort_c1", busy_o & ~in_ready_o & ~out_valid_o, 1'b1);
        tick();
        tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk1("abort_busy", busy_o, 1'b0);
        chk1("abort_out_valid", out_valid_o, 1'b0);
        chk1("abort_in_ready", in_ready_o, 1'b1);
        chk1("abort_no_done", done_o, 1'b0);
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        push_exp(b);
        load_batch(b, 1'b0, -1);
        sort_phase(7);
        drain_phase(1'b0);

        // Reset in cycle 3 of SORT.
        b = '{8'hA0, 8'h10, 8'h90, 8'h20, 8'h80, 8'h30, 8'h70, 8'h40};
        load_batch(b, 1'b0, -1);
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk1("rstmid_busy", busy_o, 1'b0);
        chk1("rstmid_out_valid", out_valid_o, 1'b0);
        chk8("rstmid_cmp", cmp_count_o, 8'h00);
        tick();
        chk1("rstmid_in_ready", in_ready_o, 1'b1);
        chk1("rstmid_no_done", done_o, 1'b0);
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        push_exp(b);
        load_batch(b, 1'b0, -1);
        sort_phase(7);
        drain_phase(1'b0);

        // Input gap between words 3 and 4.
        b = '{8'h09, 8'h03, 8'h07, 8'h01, 8'h08, 8'h02, 8'h06, 8'h04};
        e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07, 8'h08, 8'h09};
        push_exp(e);
        load_batch(b, 1'b0, 3);
        sort_phase(-1);
        drain_phase(1'b0);

        tick();
        chk1("final_done_low", done_o, 1'b0);
        chk1("final_idle", busy_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
